// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage LC-3b pipeline.
//   It drives the load and flush strobes of the IF/ID, ID/EX, EX/MEM and
//   MEM/WB stage registers, and the PC load.
//
//   Ports
//     clk, reset_sig            : clock, synchronous active-high reset
//     id_rs/id_rt, id_uses_*    : source registers of the instruction in ID
//     ex_dr, ex_mem_read,
//     ex_regfile_we             : destination and type of the instruction in EX
//     branch_taken              : MEM stage resolved a taken control transfer
//     imem_resp                 : I-cache response valid
//     dmem_req, dmem_resp       : D-cache request and response
//     cnt_clr                   : clears the performance counters
//     pc_load, *_load           : PC and stage-register load strobes
//     if/id/ex_reset            : stage-register flush (takes effect with load)
//     stall_cnt/bubble_cnt/
//     flush_cnt                 : saturating performance counters
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_sig,
    input  logic [2:0]           id_rs,
    input  logic [2:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [2:0]           ex_dr,
    input  logic                 ex_mem_read,
    input  logic                 ex_regfile_we,
    input  logic                 branch_taken,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 cnt_clr,
    output logic                 pc_load,
    output logic                 if_load,
    output logic                 id_load,
    output logic                 ex_load,
    output logic                 mem_load,
    output logic                 if_reset,
    output logic                 id_reset,
    output logic                 ex_reset,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] bubble_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_STALL  = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic mem_busy, hazard, flush_now, bubble_now;

    assign mem_busy = !imem_resp || (dmem_req && !dmem_resp);

    // R0 is an ordinary register on LC-3b, so no zero-register exclusion.
    assign hazard = ex_mem_read && ex_regfile_we &&
                    ((id_uses_rs && (id_rs == ex_dr)) ||
                     (id_uses_rt && (id_rt == ex_dr)));

    // A branch seen during a stall is remembered in FLUSH_PEND and
    // performed on the first cycle the memories are ready again.
    assign flush_now  = !mem_busy && (branch_taken || (state == FLUSH_PEND));
    assign bubble_now = hazard && !mem_busy && !flush_now;

    always_ff @(posedge clk) begin
        if (reset_sig) state <= RUN;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN, MEM_STALL: begin
                if (mem_busy && branch_taken) state_nxt = FLUSH_PEND;
                else if (mem_busy)            state_nxt = MEM_STALL;
                else                          state_nxt = RUN;
            end
            FLUSH_PEND: begin
                if (!mem_busy) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_load  = 1'b1;
        if_load  = 1'b1;
        id_load  = 1'b1;
        ex_load  = 1'b1;
        mem_load = 1'b1;
        if_reset = 1'b0;
        id_reset = 1'b0;
        ex_reset = 1'b0;
        if (reset_sig) begin
            // Clear every stage register on the next edge; PC has its own reset.
            pc_load  = 1'b0;
            if_reset = 1'b1;
            id_reset = 1'b1;
            ex_reset = 1'b1;
        end else if (mem_busy) begin
            pc_load  = 1'b0;
            if_load  = 1'b0;
            id_load  = 1'b0;
            ex_load  = 1'b0;
            mem_load = 1'b0;
        end else if (flush_now) begin
            // MEM/WB loads normally: the branch itself retires.
            if_reset = 1'b1;
            id_reset = 1'b1;
            ex_reset = 1'b1;
        end else if (bubble_now) begin
            pc_load  = 1'b0;
            if_load  = 1'b0;
            id_reset = 1'b1;
        end
    end

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset_sig || cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (mem_busy   && stall_cnt  != CNT_MAX) stall_cnt  <= stall_cnt  + 1'b1;
            if (bubble_now && bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + 1'b1;
            if (flush_now  && flush_cnt  != CNT_MAX) flush_cnt  <= flush_cnt  + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Counters are narrowed to 4 bits
// so saturation is reachable in a few cycles.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    // Strobe vector: {pc, if, id, ex, mem loads, if, id, ex resets}
    localparam logic [7:0] S_RESET  = 8'b0_1111_111;
    localparam logic [7:0] S_NORMAL = 8'b1_1111_000;
    localparam logic [7:0] S_FREEZE = 8'b0_0000_000;
    localparam logic [7:0] S_FLUSH  = 8'b1_1111_111;
    localparam logic [7:0] S_BUBBLE = 8'b0_0111_010;

    logic clk = 1'b0;
    logic reset_sig;
    logic [2:0] id_rs, id_rt, ex_dr;
    logic id_uses_rs, id_uses_rt, ex_mem_read, ex_regfile_we;
    logic branch_taken, imem_resp, dmem_req, dmem_resp, cnt_clr;
    logic pc_load, if_load, id_load, ex_load, mem_load;
    logic if_reset, id_reset, ex_reset;
    logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_sig(reset_sig),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_dr(ex_dr), .ex_mem_read(ex_mem_read), .ex_regfile_we(ex_regfile_we),
        .branch_taken(branch_taken), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp), .cnt_clr(cnt_clr),
        .pc_load(pc_load), .if_load(if_load), .id_load(id_load), .ex_load(ex_load),
        .mem_load(mem_load), .if_reset(if_reset), .id_reset(id_reset), .ex_reset(ex_reset),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    wire [7:0] strobes = {pc_load, if_load, id_load, ex_load, mem_load,
                          if_reset, id_reset, ex_reset};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are changed 1 time unit after the rising edge; outputs are
    // sampled 1 more unit later, well clear of either clock edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int s, input int b, input int f);
        chk({tag, ".stall"},  32'(stall_cnt),  32'(s));
        chk({tag, ".bubble"}, 32'(bubble_cnt), 32'(b));
        chk({tag, ".flush"},  32'(flush_cnt),  32'(f));
    endtask

    initial begin
        reset_sig = 1; id_rs = 0; id_rt = 0; ex_dr = 0;
        id_uses_rs = 0; id_uses_rt = 0; ex_mem_read = 0; ex_regfile_we = 0;
        branch_taken = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; cnt_clr = 0;

        // Reset held 2 cycles with the I-cache busy
        for (int i = 0; i < 2; i++) begin
            settle(); chk("reset_strobes", 32'(strobes), 32'(S_RESET));
            tick();
        end
        reset_sig = 0; imem_resp = 1;
        settle(); chk("post_reset_strobes", 32'(strobes), 32'(S_NORMAL));
        chk_cnt("post_reset", 0, 0, 0);
        tick();

        // Load-use through rs
        ex_mem_read = 1; ex_regfile_we = 1; ex_dr = 3; id_rs = 3; id_uses_rs = 1;
        settle(); chk("bubble_rs", 32'(strobes), 32'(S_BUBBLE));
        tick(); chk_cnt("bubble_rs", 0, 1, 0);
        // Same registers but rs is not read
        id_uses_rs = 0;
        settle(); chk("no_bubble_unused", 32'(strobes), 32'(S_NORMAL));
        tick(); chk_cnt("no_bubble_unused", 0, 1, 0);
        // Load-use through rt, on R0 (no R0 exclusion)
        ex_dr = 0; id_rt = 0; id_rs = 5; id_uses_rt = 1;
        settle(); chk("bubble_rt_r0", 32'(strobes), 32'(S_BUBBLE));
        tick(); chk_cnt("bubble_rt_r0", 0, 2, 0);
        // Not a load: no bubble
        ex_mem_read = 0;
        settle(); chk("no_bubble_alu", 32'(strobes), 32'(S_NORMAL));
        tick();

        // Taken branch with a concurrent hazard: flush wins
        ex_mem_read = 1; branch_taken = 1;
        settle(); chk("flush_over_hazard", 32'(strobes), 32'(S_FLUSH));
        tick(); chk_cnt("flush1", 0, 2, 1);
        branch_taken = 0; ex_mem_read = 0; id_uses_rt = 0;

        // D-cache stall for 4 cycles
        dmem_req = 1; dmem_resp = 0;
        for (int i = 0; i < 4; i++) begin
            settle(); chk("dstall_freeze", 32'(strobes), 32'(S_FREEZE));
            tick();
        end
        chk_cnt("dstall", 4, 2, 1);
        dmem_resp = 1;
        settle(); chk("dstall_resp", 32'(strobes), 32'(S_NORMAL));
        tick(); chk_cnt("dstall_done", 4, 2, 1);
        dmem_req = 0; dmem_resp = 0;

        // Pending flush: branch pulse on stall cycle 2 of 5
        dmem_req = 1;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 1);
            settle(); chk("pend_freeze", 32'(strobes), 32'(S_FREEZE));
            tick();
        end
        branch_taken = 0;
        chk("pend_state", 32'(dut.state), 32'd2);
        dmem_resp = 1;
        settle(); chk("pend_flush", 32'(strobes), 32'(S_FLUSH));
        tick(); chk_cnt("pend_flush", 9, 2, 2);
        chk("pend_state_run", 32'(dut.state), 32'd0);
        dmem_req = 0; dmem_resp = 0;
        settle(); chk("pend_after", 32'(strobes), 32'(S_NORMAL));
        tick(); chk_cnt("pend_after", 9, 2, 2);

        // Saturation: 10 more stall cycles from 9 must stop at 15
        imem_resp = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("stall_sat", 32'(stall_cnt), 32'd15);
        tick(); chk("stall_sat_hold", 32'(stall_cnt), 32'd15);
        // Clear during a stall beats the increment
        cnt_clr = 1;
        tick(); chk_cnt("clr", 0, 0, 0);
        cnt_clr = 0;
        tick(); chk("clr_restart", 32'(stall_cnt), 32'd1);

        // Reset mid-stall with a pending flush
        imem_resp = 1; dmem_req = 1; dmem_resp = 0; branch_taken = 1;
        tick(); branch_taken = 0;
        reset_sig = 1;
        settle(); chk("reset_midstall", 32'(strobes), 32'(S_RESET));
        tick();
        reset_sig = 0; dmem_req = 0;
        settle(); chk("reset_drop_pend", 32'(strobes), 32'(S_NORMAL));
        chk_cnt("reset_midstall", 0, 0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
